// File: rtl/collision_monitor.sv
// Frog/obstacle collision monitor: lives, hit row, goal detection and game sequencing.
// Optional post-hit immunity window is built when COLLISION_GRACE_EN is defined.
module collision_monitor #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int LIVES        = 3,
   parameter int GOAL_ROW     = 7,
   parameter int GRACE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     restart,
   input  logic [ROWS*COLS-1:0]     obsMove,
   input  logic [ROWS*COLS-1:0]     frogMove,
   output logic                     resetField,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] hitRow,
   output logic [3:0]               livesLeft,
   output logic                     gameOver,
   output logic                     win
);

   localparam int HW = (ROWS > 1) ? $clog2(ROWS) : 1;

   // Out-of-range parameters elaborate this named marker block so the
   // misconfiguration is visible in the elaborated hierarchy.
   if (LIVES < 1 || LIVES > 15 || GRACE_CYCLES < 1 || GOAL_ROW >= ROWS) begin : g_param_out_of_range
   end

`ifdef COLLISION_GRACE_EN
   localparam int GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;

   typedef enum logic [2:0] {
      PLAY  = 3'd0,
      HIT   = 3'd1,
      OVER  = 3'd2,
      WON   = 3'd3,
      GRACE = 3'd4
   } state_t;

   logic [GW-1:0] grace_cnt, grace_cnt_next;
`else
   typedef enum logic [1:0] {
      PLAY = 2'd0,
      HIT  = 2'd1,
      OVER = 2'd2,
      WON  = 2'd3
   } state_t;
`endif

   state_t state, state_next;

   logic          hit;
   logic          goal;
   logic [HW-1:0] first_row;

   logic          reset_field_next;
   logic [HW-1:0] hit_row_next;
   logic [3:0]    lives_next;
   logic          game_over_next;
   logic          win_next;

   // Scan from the top row downwards so the lowest colliding row is kept.
   always_comb begin
      hit       = 1'b0;
      first_row = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (|(obsMove[r*COLS +: COLS] & frogMove[r*COLS +: COLS])) begin
            hit       = 1'b1;
            first_row = HW'(r);
         end
      end
      goal = |frogMove[GOAL_ROW*COLS +: COLS];
   end

   always_comb begin
      state_next       = state;
      reset_field_next = 1'b0;
      hit_row_next     = hitRow;
      lives_next       = livesLeft;
      game_over_next   = gameOver;
      win_next         = win;
`ifdef COLLISION_GRACE_EN
      grace_cnt_next   = grace_cnt;
`endif

      if (restart) begin
         // Toggling keeps a held restart from driving resetField high back to back.
         state_next       = PLAY;
         lives_next       = 4'(LIVES);
         hit_row_next     = '0;
         game_over_next   = 1'b0;
         win_next         = 1'b0;
         reset_field_next = ~resetField;
`ifdef COLLISION_GRACE_EN
         grace_cnt_next   = '0;
`endif
      end else begin
         case (state)
            PLAY: begin
               if (hit) begin
                  hit_row_next     = first_row;
                  reset_field_next = 1'b1;
                  if (livesLeft <= 4'd1) begin
                     lives_next     = 4'd0;
                     game_over_next = 1'b1;
                     state_next     = OVER;
                  end else begin
                     lives_next = livesLeft - 4'd1;
                     state_next = HIT;
                  end
               end else if (goal) begin
                  win_next         = 1'b1;
                  reset_field_next = 1'b1;
                  state_next       = WON;
               end
            end
            HIT: begin
`ifdef COLLISION_GRACE_EN
               grace_cnt_next = GW'(GRACE_CYCLES - 1);
               state_next     = GRACE;
`else
               state_next     = PLAY;
`endif
            end
`ifdef COLLISION_GRACE_EN
            GRACE: begin
               if (goal) begin
                  win_next         = 1'b1;
                  reset_field_next = 1'b1;
                  grace_cnt_next   = '0;
                  state_next       = WON;
               end else if (grace_cnt == '0) begin
                  state_next = PLAY;
               end else begin
                  grace_cnt_next = grace_cnt - GW'(1);
               end
            end
`endif
            OVER: state_next = OVER;
            WON:  state_next = WON;
            default: state_next = PLAY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= PLAY;
         resetField <= 1'b0;
         hitRow     <= '0;
         livesLeft  <= 4'(LIVES);
         gameOver   <= 1'b0;
         win        <= 1'b0;
`ifdef COLLISION_GRACE_EN
         grace_cnt  <= '0;
`endif
      end else begin
         state      <= state_next;
         resetField <= reset_field_next;
         hitRow     <= hit_row_next;
         livesLeft  <= lives_next;
         gameOver   <= game_over_next;
         win        <= win_next;
`ifdef COLLISION_GRACE_EN
         grace_cnt  <= grace_cnt_next;
`endif
      end
   end

endmodule

// File: tb/tb_collision_monitor.sv
// Directed self-checking bench for collision_monitor (8x8 map, 3 lives, goal row 7).
module tb_collision_monitor;

   logic        clk;
   logic        reset;
   logic        restart;
   logic [63:0] obs_move;
   logic [63:0] frog_move;
   logic        reset_field;
   logic [2:0]  hit_row;
   logic [3:0]  lives_left;
   logic        game_over;
   logic        win;

   int tests_run;
   int tests_failed;
   int first_gap;

`ifdef COLLISION_GRACE_EN
   localparam int EXP_GAP = 6;
`else
   localparam int EXP_GAP = 2;
`endif

   collision_monitor #(
      .ROWS(8), .COLS(8), .LIVES(3), .GOAL_ROW(7), .GRACE_CYCLES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .restart(restart),
      .obsMove(obs_move),
      .frogMove(frog_move),
      .resetField(reset_field),
      .hitRow(hit_row),
      .livesLeft(lives_left),
      .gameOver(game_over),
      .win(win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] rowBits(input int r, input logic [7:0] bits);
      logic [63:0] v;
      v = '0;
      v[r*8 +: 8] = bits;
      return v;
   endfunction

   task automatic applyStimulus(input logic [63:0] frog, input logic [63:0] obs, input logic rst_req);
      frog_move = frog;
      obs_move  = obs;
      restart   = rst_req;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      restart      = 1'b0;
      obs_move     = '0;
      frog_move    = '0;
      #12 reset = 1'b0;
      @(negedge clk);

      checkOutput("reset_lives", 32'(lives_left), 32'd3);
      checkOutput("reset_row", 32'(hit_row), 32'd0);
      checkOutput("reset_rf", 32'(reset_field), 32'd0);
      checkOutput("reset_over", 32'(game_over), 32'd0);
      checkOutput("reset_win", 32'(win), 32'd0);

      // single row-0 overlap
      applyStimulus(rowBits(0, 8'h40), rowBits(0, 8'h40), 1'b0);
      checkOutput("t1_rf", 32'(reset_field), 32'd1);
      checkOutput("t1_lives", 32'(lives_left), 32'd2);
      checkOutput("t1_row", 32'(hit_row), 32'd0);
      applyStimulus('0, '0, 1'b0);
      checkOutput("t1_rf_drop", 32'(reset_field), 32'd0);
      checkOutput("t1_lives_hold", 32'(lives_left), 32'd2);

      // rows 3 and 5 overlap together, lowest row reported
      applyStimulus(rowBits(3, 8'h10) | rowBits(5, 8'h10),
                    rowBits(3, 8'h90) | rowBits(5, 8'h10), 1'b0);
      checkOutput("t2_row", 32'(hit_row), 32'd3);
      checkOutput("t2_lives", 32'(lives_left), 32'd1);
      checkOutput("t2_rf", 32'(reset_field), 32'd1);
      applyStimulus('0, '0, 1'b0);
      checkOutput("t2_lives_hold", 32'(lives_left), 32'd1);
      checkOutput("t2_row_hold", 32'(hit_row), 32'd3);

      // restart, then three separated hits to game over
      applyStimulus('0, '0, 1'b1);
      checkOutput("t3_restart_lives", 32'(lives_left), 32'd3);
      checkOutput("t3_restart_row", 32'(hit_row), 32'd0);
      applyStimulus('0, '0, 1'b0);
`ifdef COLLISION_GRACE_EN
      repeat (6) applyStimulus('0, '0, 1'b0);
`endif
      applyStimulus(rowBits(2, 8'h01), rowBits(2, 8'h01), 1'b0);
      checkOutput("t3_hit1_lives", 32'(lives_left), 32'd2);
      checkOutput("t3_hit1_row", 32'(hit_row), 32'd2);
      repeat (6) applyStimulus('0, '0, 1'b0);
      applyStimulus(rowBits(1, 8'h80), rowBits(1, 8'hFF), 1'b0);
      checkOutput("t3_hit2_lives", 32'(lives_left), 32'd1);
      checkOutput("t3_hit2_row", 32'(hit_row), 32'd1);
      repeat (6) applyStimulus('0, '0, 1'b0);
      applyStimulus(rowBits(4, 8'h02), rowBits(4, 8'h06), 1'b0);
      checkOutput("t3_hit3_lives", 32'(lives_left), 32'd0);
      checkOutput("t3_hit3_over", 32'(game_over), 32'd1);
      checkOutput("t3_hit3_row", 32'(hit_row), 32'd4);
      checkOutput("t3_hit3_rf", 32'(reset_field), 32'd1);
      applyStimulus('0, '0, 1'b0);
      checkOutput("t3_over_rf_drop", 32'(reset_field), 32'd0);
      applyStimulus(rowBits(0, 8'h01), rowBits(0, 8'h01), 1'b0);
      checkOutput("t3_hit4_lives", 32'(lives_left), 32'd0);
      checkOutput("t3_hit4_rf", 32'(reset_field), 32'd0);
      checkOutput("t3_hit4_row", 32'(hit_row), 32'd4);
      checkOutput("t3_hit4_over", 32'(game_over), 32'd1);

      // restart from OVER
      applyStimulus('0, '0, 1'b1);
      checkOutput("t5_lives", 32'(lives_left), 32'd3);
      checkOutput("t5_over", 32'(game_over), 32'd0);
      checkOutput("t5_row", 32'(hit_row), 32'd0);
      checkOutput("t5_rf", 32'(reset_field), 32'd1);
      applyStimulus('0, '0, 1'b0);
      checkOutput("t5_rf_once", 32'(reset_field), 32'd0);

      // goal row reached without overlap
      applyStimulus(rowBits(7, 8'h08), '0, 1'b0);
      checkOutput("t4_win", 32'(win), 32'd1);
      checkOutput("t4_rf", 32'(reset_field), 32'd1);
      applyStimulus(rowBits(0, 8'h01), rowBits(0, 8'h01), 1'b0);
      checkOutput("t4_won_rf", 32'(reset_field), 32'd0);
      checkOutput("t4_won_lives", 32'(lives_left), 32'd3);
      checkOutput("t4_won_win", 32'(win), 32'd1);

      // goal and overlap together: the hit wins
      applyStimulus('0, '0, 1'b1);
      checkOutput("t4_restart_win", 32'(win), 32'd0);
      applyStimulus('0, '0, 1'b0);
      applyStimulus(rowBits(7, 8'h08), rowBits(7, 8'h08), 1'b0);
      checkOutput("t4_both_win", 32'(win), 32'd0);
      checkOutput("t4_both_lives", 32'(lives_left), 32'd2);
      checkOutput("t4_both_row", 32'(hit_row), 32'd7);
      checkOutput("t4_both_rf", 32'(reset_field), 32'd1);
      applyStimulus('0, '0, 1'b0);
      checkOutput("t4_both_rf_drop", 32'(reset_field), 32'd0);
      checkOutput("t4_both_win_low", 32'(win), 32'd0);

      // async reset while the hit pulse is high
      applyStimulus('0, '0, 1'b1);
      applyStimulus('0, '0, 1'b0);
      applyStimulus(rowBits(6, 8'h20), rowBits(6, 8'h20), 1'b0);
      checkOutput("t5b_pulse", 32'(reset_field), 32'd1);
      frog_move = '0;
      obs_move  = '0;
      #2 reset = 1'b1;
      #1;
      checkOutput("t5b_async_rf", 32'(reset_field), 32'd0);
      checkOutput("t5b_async_lives", 32'(lives_left), 32'd3);
      checkOutput("t5b_async_row", 32'(hit_row), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus('0, '0, 1'b0);
      checkOutput("t5b_after_rf", 32'(reset_field), 32'd0);

      // continuous overlap: spacing between decrements
      applyStimulus(rowBits(0, 8'h01), rowBits(0, 8'h01), 1'b0);
      checkOutput("t6_first_lives", 32'(lives_left), 32'd2);
      first_gap = -1;
      for (int i = 1; i <= 20; i++) begin
         applyStimulus(rowBits(0, 8'h01), rowBits(0, 8'h01), 1'b0);
         if (first_gap < 0 && lives_left != 4'd2) first_gap = i;
      end
      checkOutput("t6_gap", 32'(first_gap), 32'(EXP_GAP));
      applyStimulus('0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
